// File: rtl/fetch_queue.sv
// Dual-width fetch queue: circular buffer of {pc, instr} between fetch and decode.
// Optional FETCHQ_STATS_EN adds stall-cycle and peak-occupancy counters.
module fetch_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     fetch_valid,
    input  logic [XLEN-1:0]          fetch_pc,
    input  logic [31:0]              fetch_instr1,
    input  logic [31:0]              fetch_instr2,
    input  logic                     fetch_slot2_valid,
    output logic                     fetch_ready,
    input  logic [1:0]               deq_count,
    output logic                     deq_valid1,
    output logic                     deq_valid2,
    output logic [XLEN-1:0]          deq_pc1,
    output logic [31:0]              deq_instr1,
    output logic [XLEN-1:0]          deq_pc2,
    output logic [31:0]              deq_instr2,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef FETCHQ_STATS_EN
    ,
    output logic [31:0]              stall_cycles,
    output logic [$clog2(DEPTH):0]   peak_occupancy
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   head_p1, tail_p1;
    logic               enq_fire;
    logic [1:0]         enq_n;
    logic [1:0]         deq_req;
    logic [1:0]         deq_n;
    logic [XLEN-1:0]    slot2_pc;

    // Status and read ports come straight from registered state; no bypass.
    always_comb begin
        head_p1     = head_q + PTR_W'(1);
        tail_p1     = tail_q + PTR_W'(1);
        fetch_ready = (count_q <= CNT_W'(DEPTH - 2));
        deq_valid1  = (count_q != '0);
        deq_valid2  = (count_q >= CNT_W'(2));
        deq_pc1     = mem_q[head_q].pc;
        deq_instr1  = mem_q[head_q].instr;
        deq_pc2     = mem_q[head_p1].pc;
        deq_instr2  = mem_q[head_p1].instr;
        occupancy   = count_q;
        slot2_pc    = fetch_pc + XLEN'(4);
    end

    // Next-state: a pair is all-or-nothing, dequeue clamps to what is held.
    always_comb begin
        enq_fire = fetch_valid && fetch_ready && !flush;
        enq_n    = 2'd0;
        if (enq_fire) begin
            enq_n = fetch_slot2_valid ? 2'd2 : 2'd1;
        end
        deq_req = (deq_count == 2'd3) ? 2'd2 : deq_count;
        deq_n   = deq_req;
        if (CNT_W'(deq_req) > count_q) begin
            deq_n = 2'(count_q);
        end
        head_d  = head_q + PTR_W'(deq_n);
        tail_d  = tail_q + PTR_W'(enq_n);
        count_d = count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage has no reset; slot 2 goes to tail+1, wrapping to index 0.
    always_ff @(posedge CLK) begin
        if (!reset && enq_fire) begin
            mem_q[tail_q] <= '{pc: fetch_pc, instr: fetch_instr1};
            if (fetch_slot2_valid) begin
                mem_q[tail_p1] <= '{pc: slot2_pc, instr: fetch_instr2};
            end
        end
    end

`ifdef FETCHQ_STATS_EN
    logic [31:0]      stall_q, stall_d;
    logic [CNT_W-1:0] peak_q, peak_d;

    // Statistics survive flush; only reset clears them.
    always_comb begin
        stall_d = stall_q;
        if (fetch_valid && !fetch_ready && !flush && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
        peak_d = (count_d > peak_q) ? count_d : peak_q;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            stall_q <= '0;
            peak_q  <= '0;
        end else begin
            stall_q <= stall_d;
            peak_q  <= peak_d;
        end
    end

    assign stall_cycles   = stall_q;
    assign peak_occupancy = peak_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based scoreboard of expected entries.
module tb_fetch_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              CLK = 1'b0;
    logic              reset;
    logic              flush;
    logic              fetch_valid;
    logic [XLEN-1:0]   fetch_pc;
    logic [31:0]       fetch_instr1;
    logic [31:0]       fetch_instr2;
    logic              fetch_slot2_valid;
    logic              fetch_ready;
    logic [1:0]        deq_count;
    logic              deq_valid1;
    logic              deq_valid2;
    logic [XLEN-1:0]   deq_pc1;
    logic [31:0]       deq_instr1;
    logic [XLEN-1:0]   deq_pc2;
    logic [31:0]       deq_instr2;
    logic [CNT_W-1:0]  occupancy;
`ifdef FETCHQ_STATS_EN
    logic [31:0]       stall_cycles;
    logic [CNT_W-1:0]  peak_occupancy;
    int unsigned       exp_stall = 0;
`endif

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .CLK               (CLK),
        .reset             (reset),
        .flush             (flush),
        .fetch_valid       (fetch_valid),
        .fetch_pc          (fetch_pc),
        .fetch_instr1      (fetch_instr1),
        .fetch_instr2      (fetch_instr2),
        .fetch_slot2_valid (fetch_slot2_valid),
        .fetch_ready       (fetch_ready),
        .deq_count         (deq_count),
        .deq_valid1        (deq_valid1),
        .deq_valid2        (deq_valid2),
        .deq_pc1           (deq_pc1),
        .deq_instr1        (deq_instr1),
        .deq_pc2           (deq_pc2),
        .deq_instr2        (deq_instr2),
        .occupancy         (occupancy)
`ifdef FETCHQ_STATS_EN
        ,
        .stall_cycles      (stall_cycles),
        .peak_occupancy    (peak_occupancy)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t model[$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic model_ready();
        return (DEPTH - model.size()) >= 2;
    endfunction

    task automatic check_outputs(input string tag);
        int n;
        n = model.size();
        chk({tag, "_occ"},    64'(occupancy),   64'(n));
        chk({tag, "_v1"},     64'(deq_valid1),  64'(n >= 1));
        chk({tag, "_v2"},     64'(deq_valid2),  64'(n >= 2));
        chk({tag, "_ready"},  64'(fetch_ready), 64'(model_ready()));
        if (n >= 1) begin
            chk({tag, "_pc1"},    64'(deq_pc1),    64'(model[0].pc));
            chk({tag, "_instr1"}, 64'(deq_instr1), 64'(model[0].instr));
        end
        if (n >= 2) begin
            chk({tag, "_pc2"},    64'(deq_pc2),    64'(model[1].pc));
            chk({tag, "_instr2"}, 64'(deq_instr2), 64'(model[1].instr));
        end
    endtask

    // One clock of stimulus; the scoreboard is updated with what the queue should hold afterwards.
    task automatic step(input string tag, input logic fv, input logic [31:0] pc,
                        input logic [31:0] i1, input logic [31:0] i2, input logic s2,
                        input logic [1:0] dc, input logic fl);
        logic rdy;
        int   n;
        ent_t e;
        fetch_valid       = fv;
        fetch_pc          = pc;
        fetch_instr1      = i1;
        fetch_instr2      = i2;
        fetch_slot2_valid = s2;
        deq_count         = dc;
        flush             = fl;
        rdy = model_ready();
`ifdef FETCHQ_STATS_EN
        if (fv && !rdy && !fl) exp_stall++;
`endif
        if (fl) begin
            model.delete();
        end else begin
            n = (dc > 2'd1) ? 2 : int'(dc);
            if (n > model.size()) n = model.size();
            repeat (n) void'(model.pop_front());
            if (fv && rdy) begin
                e.pc = pc; e.instr = i1;
                model.push_back(e);
                if (s2) begin
                    e.pc = pc + 32'd4; e.instr = i2;
                    model.push_back(e);
                end
            end
        end
        @(posedge CLK);
        #1;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        deq_count   = 2'd0;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        deq_count   = 2'd0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        reset = 1'b0;
        model.delete();
`ifdef FETCHQ_STATS_EN
        exp_stall = 0;
`endif
        check_outputs("rst");
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_pc = '0;
        fetch_instr1 = '0; fetch_instr2 = '0; fetch_slot2_valid = 1'b0; deq_count = 2'd0;
        do_reset();
        for (int i = 0; i < 5; i++) step("idle", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);

        // Basic pair then single dequeue.
        step("pair", 1'b1, 32'h100, 32'hA, 32'hB, 1'b1, 2'd0, 1'b0);
        chk("pair_pc2_const", 64'(deq_pc2), 64'h104);
        chk("pair_occ_const", 64'(occupancy), 64'd2);
        step("deq1", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd1, 1'b0);
        chk("deq1_pc1_const", 64'(deq_pc1), 64'h104);
        chk("deq1_v2_const", 64'(deq_valid2), 64'd0);
        step("drain", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd1, 1'b0);

        // Fill to full, hold a 5th pair, release with a double dequeue.
        for (int i = 0; i < 4; i++)
            step("fill", 1'b1, 32'(i * 8), 32'(16'h1000 + i), 32'(16'h2000 + i), 1'b1, 2'd0, 1'b0);
        chk("full_occ_const", 64'(occupancy), 64'd8);
        chk("full_ready_const", 64'(fetch_ready), 64'd0);
        step("held", 1'b1, 32'h20, 32'h1004, 32'h2004, 1'b1, 2'd0, 1'b0);
        chk("held_occ_const", 64'(occupancy), 64'd8);
        step("release", 1'b1, 32'h20, 32'h1004, 32'h2004, 1'b1, 2'd2, 1'b0);
        chk("release_ready_const", 64'(fetch_ready), 64'd1);
        step("accept5", 1'b1, 32'h20, 32'h1004, 32'h2004, 1'b1, 2'd0, 1'b0);
        step("full_deq", 1'b1, 32'h28, 32'h1005, 32'h2005, 1'b1, 2'd2, 1'b0);
        for (int i = 0; i < 4; i++) step("drain2", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0);

        // Park pointers at 7, preload 7, dequeue 6, single then a wrapping pair.
        do_reset();
        for (int i = 0; i < 7; i++)
            step("park", 1'b1, 32'(32'h200 + i * 4), 32'(i), 32'h0, 1'b0, 2'd1, 1'b0);
        step("park_last", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd1, 1'b0);
        for (int i = 0; i < 3; i++)
            step("pre", 1'b1, 32'(32'h300 + i * 8), 32'(32'h30 + i), 32'(32'h40 + i), 1'b1, 2'd0, 1'b0);
        step("pre_single", 1'b1, 32'h318, 32'h33, 32'h0, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) step("deq6", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0);
        chk("deq6_occ_const", 64'(occupancy), 64'd1);
        step("s2drop", 1'b1, 32'h40, 32'hC0, 32'hDEAD, 1'b0, 2'd0, 1'b0);
        chk("s2drop_pc2_const", 64'(deq_pc2), 64'h40);
        step("wrap", 1'b1, 32'h80, 32'hE0, 32'hE1, 1'b1, 2'd0, 1'b0);
        step("wrap_d1", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0);
        chk("wrap_pc1_const", 64'(deq_pc1), 64'h80);
        chk("wrap_pc2_const", 64'(deq_pc2), 64'h84);
        step("wrap_d2", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0);

        // Flush wins over same-cycle enqueue and dequeue.
        step("f_a", 1'b1, 32'h500, 32'h50, 32'h51, 1'b1, 2'd0, 1'b0);
        step("f_b", 1'b1, 32'h508, 32'h52, 32'h53, 1'b1, 2'd0, 1'b0);
        step("f_c", 1'b1, 32'h510, 32'h54, 32'h0, 1'b0, 2'd0, 1'b0);
        chk("f_occ5_const", 64'(occupancy), 64'd5);
        step("flush", 1'b1, 32'h600, 32'h60, 32'h61, 1'b1, 2'd2, 1'b1);
        chk("flush_occ_const", 64'(occupancy), 64'd0);
        step("post_flush", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        step("after_flush", 1'b1, 32'h700, 32'h70, 32'h71, 1'b1, 2'd0, 1'b0);
        chk("after_flush_pc1_const", 64'(deq_pc1), 64'h700);
        step("after_flush_d", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0);

        // Over-dequeue clamps at empty.
        step("od_a", 1'b1, 32'h800, 32'h80, 32'h0, 1'b0, 2'd0, 1'b0);
        step("od", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd3, 1'b0);
        chk("od_occ_const", 64'(occupancy), 64'd0);
        step("od_empty", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd3, 1'b0);

        // Random pairs with random dequeue against the scoreboard.
        for (int i = 0; i < 60; i++)
            step("rnd", 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0));
`ifdef FETCHQ_STATS_EN
        chk("peak", 64'(peak_occupancy), 64'd8);
        chk("stall", 64'(stall_cycles), 64'(exp_stall));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
